ms_section_scheduler: RTL and testbench
=======================================

# ms_section_scheduler

Two-requester scheduler that shares one blocking master output channel between slave inputs A and B. Each slave input is an integer value qualified by a sync flag. The block captures one value per grant and holds it on the master port until the downstream consumer accepts it. Grants alternate round-robin when both requesters compete. It sits between producer sections and the single shared master port, and owns the section register that records which requester is being served.

## Interface
- WIDTH, 32, data width of inputs and output
- RESET_VAL, 1337, value driven on m_out after reset
- CNT_W, 8, width of per-requester transfer counters

- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- a_in  in  WIDTH  requester A data
- a_in_sync  in  1  requester A has valid data (level, held until grant)
- b_in  in  WIDTH  requester B data
- b_in_sync  in  1  requester B has valid data (level, held until grant)
- m_out  out  WIDTH  captured value presented to consumer
- m_out_valid  out  1  m_out holds an unaccepted value
- m_out_ready  in  1  consumer accepts m_out this cycle
- grant_a  out  1  one-cycle pulse: a_in captured
- grant_b  out  1  one-cycle pulse: b_in captured
- section  out  2  current state encoding: 0 IDLE, 1 SEND_A, 2 SEND_B
- cnt_a  out  CNT_W  completed A transfers, wraps modulo 2^CNT_W
- cnt_b  out  CNT_W  completed B transfers, wraps modulo 2^CNT_W

## Operation
- Reset values: section=IDLE, m_out=RESET_VAL, m_out_valid=0, grant_a=grant_b=0, cnt_a=cnt_b=0, last_served=B (so A wins the first tie).
- All outputs are registered.
- IDLE, exactly one sync high: capture that input into m_out, set m_out_valid=1, pulse that requester's grant, and go to SEND_A or SEND_B.
- IDLE, both syncs high: grant the requester not equal to last_served. The loser stays pending; its sync must stay high.
- IDLE, no sync high: hold state. m_out keeps its last value and m_out_valid stays 0.
- SEND_x, m_out_ready=0: hold. m_out is stable, sync inputs are ignored, and no grant is issued.
- SEND_x, m_out_ready=1:
  - transfer completes: m_out_valid becomes 0, cnt_x increments (wrapping), last_served becomes x, next state IDLE;
  - m_out keeps the sent value.
- Requester protocol: drop sync in the cycle after grant_x is seen, or re-present new data. A sync still high in IDLE after the previous transfer is treated as a new request.
- Asynchronous rst in any state: immediately returns all outputs to reset values. An in-flight transfer is discarded and its counter is not incremented.

## Timing
- Capture latency: with sync sampled high at IDLE edge k, the values below are all visible after edge k:
  - m_out = input,
  - m_out_valid = 1,
  - grant_x = 1 for that one cycle only,
  - section = SEND_x.
- Completion: m_out_valid and m_out_ready both high at edge j gives m_out_valid=0, cnt_x+1 and section=IDLE after edge j.
- Earliest next capture is edge j+1. There is one bubble cycle between transfers.
- Minimum period per transfer is 2 cycles with m_out_ready held at 1.
- m_out_ready while m_out_valid=0 is ignored.
- grant_a and grant_b are never high together.

## Test plan
- Reset: assert rst mid-SEND_B with m_out_valid=1 -> m_out=1337, valid=0, section=0, cnt_b unchanged from 0, grants 0.
- Single A transfer: a_in=5, a_in_sync=1 in IDLE, m_out_ready=1 -> after edge 1 m_out=5, valid=1, grant_a=1; after edge 2 valid=0, cnt_a=1, section=0.
- Tie and round-robin: both syncs high, a_in=10, b_in=20, ready=1 -> sequence 10 (A), 20 (B), 10 (A); grants alternate with one bubble each; cnt_a=2, cnt_b=1 after 6 cycles.
- Backpressure: B captured with b_in=7 and ready=0 for 4 cycles while b_in changes to 9 and a_in_sync=1 -> m_out stays 7, no grants, section=2; then ready=1 completes B, and A is granted next cycle.
- Counter wrap: 256 A transfers -> cnt_a returns to 0, cnt_b=0.
- Idle hold: after one transfer of 42, no syncs for 10 cycles -> m_out=42, valid=0, section=0 throughout.

Source files
------------

// File: rtl/ms_section_scheduler.sv
// -----------------------------------------------------------------------------
// ms_section_scheduler
//
// Shares one blocking master output channel between two requesters, A and B.
// Each grant captures one value into m_out. The value stays on m_out until the
// consumer accepts it. When both requesters compete, they are served
// round-robin. The section register records which requester owns the channel.
//
// Ports
//   clk, rst          clock, asynchronous active-high reset
//   a_in, a_in_sync   requester A data and request level
//   b_in, b_in_sync   requester B data and request level
//   m_out             captured value presented to the consumer
//   m_out_valid       m_out holds a value that has not been accepted
//   m_out_ready       consumer accepts m_out this cycle
//   grant_a, grant_b  one-cycle pulse: that requester's data was captured
//   section           0 IDLE, 1 SEND_A, 2 SEND_B
//   cnt_a, cnt_b      completed transfers per requester, wrapping
// -----------------------------------------------------------------------------
module ms_section_scheduler #(
  parameter int               WIDTH     = 32,
  parameter logic [WIDTH-1:0] RESET_VAL = WIDTH'(1337),
  parameter int               CNT_W     = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a_in,
  input  logic             a_in_sync,
  input  logic [WIDTH-1:0] b_in,
  input  logic             b_in_sync,
  output logic [WIDTH-1:0] m_out,
  output logic             m_out_valid,
  input  logic             m_out_ready,
  output logic             grant_a,
  output logic             grant_b,
  output logic [1:0]       section,
  output logic [CNT_W-1:0] cnt_a,
  output logic [CNT_W-1:0] cnt_b
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SEND_A = 2'd1,
    SEND_B = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] m_out_q, m_out_d;
  logic             valid_q, valid_d;
  logic             grant_a_q, grant_a_d;
  logic             grant_b_q, grant_b_d;
  logic [CNT_W-1:0] cnt_a_q, cnt_a_d;
  logic [CNT_W-1:0] cnt_b_q, cnt_b_d;
  // Set when B was served last. It resets to 1 so that A wins the first tie.
  logic             last_b_q, last_b_d;

  logic pick_a;
  logic pick_b;

  // When both requesters are active, the one not served last wins.
  assign pick_a = a_in_sync && (!b_in_sync || last_b_q);
  assign pick_b = b_in_sync && !pick_a;

  always_comb begin
    // NOTE: every signal is given a default first. Without it, a path that
    // leaves a signal unassigned infers a latch.
    state_d   = state_q;
    m_out_d   = m_out_q;
    valid_d   = valid_q;
    grant_a_d = 1'b0;
    grant_b_d = 1'b0;
    cnt_a_d   = cnt_a_q;
    cnt_b_d   = cnt_b_q;
    last_b_d  = last_b_q;

    unique case (state_q)
      IDLE: begin
        if (pick_a) begin
          m_out_d   = a_in;
          valid_d   = 1'b1;
          grant_a_d = 1'b1;
          state_d   = SEND_A;
        end else if (pick_b) begin
          m_out_d   = b_in;
          valid_d   = 1'b1;
          grant_b_d = 1'b1;
          state_d   = SEND_B;
        end
      end
      // While a transfer is in flight, sync inputs are ignored. m_out keeps
      // the sent value after completion.
      SEND_A: begin
        if (m_out_ready) begin
          valid_d  = 1'b0;
          cnt_a_d  = cnt_a_q + CNT_W'(1);
          last_b_d = 1'b0;
          state_d  = IDLE;
        end
      end
      SEND_B: begin
        if (m_out_ready) begin
          valid_d  = 1'b0;
          cnt_b_d  = cnt_b_q + CNT_W'(1);
          last_b_d = 1'b1;
          state_d  = IDLE;
        end
      end
      default: begin
        valid_d = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  // NOTE: sequential state is updated with non-blocking assignments. Every
  // register then samples pre-edge values, and the result does not depend on
  // the order in which processes run.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      m_out_q   <= RESET_VAL;
      valid_q   <= 1'b0;
      grant_a_q <= 1'b0;
      grant_b_q <= 1'b0;
      cnt_a_q   <= '0;
      cnt_b_q   <= '0;
      last_b_q  <= 1'b1;
    end else begin
      state_q   <= state_d;
      m_out_q   <= m_out_d;
      valid_q   <= valid_d;
      grant_a_q <= grant_a_d;
      grant_b_q <= grant_b_d;
      cnt_a_q   <= cnt_a_d;
      cnt_b_q   <= cnt_b_d;
      last_b_q  <= last_b_d;
    end
  end

  assign m_out       = m_out_q;
  assign m_out_valid = valid_q;
  assign grant_a     = grant_a_q;
  assign grant_b     = grant_b_q;
  assign section     = state_q;
  assign cnt_a       = cnt_a_q;
  assign cnt_b       = cnt_b_q;

endmodule

// File: tb/tb_ms_section_scheduler.sv
// -----------------------------------------------------------------------------
// tb_ms_section_scheduler
//
// Directed testbench for ms_section_scheduler. Expected values are worked out
// by hand. Inputs change 1 time unit after the rising edge. Outputs are sampled
// at that same moment, so the bench always observes settled registers.
// -----------------------------------------------------------------------------
module tb_ms_section_scheduler;

  localparam int WIDTH = 32;
  localparam int CNT_W = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic [WIDTH-1:0] a_in;
  logic             a_in_sync;
  logic [WIDTH-1:0] b_in;
  logic             b_in_sync;
  logic [WIDTH-1:0] m_out;
  logic             m_out_valid;
  logic             m_out_ready;
  logic             grant_a;
  logic             grant_b;
  logic [1:0]       section;
  logic [CNT_W-1:0] cnt_a;
  logic [CNT_W-1:0] cnt_b;

  int n_checks = 0;
  int n_pass   = 0;

  ms_section_scheduler #(
    .WIDTH    (WIDTH),
    .RESET_VAL(32'd1337),
    .CNT_W    (CNT_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .a_in       (a_in),
    .a_in_sync  (a_in_sync),
    .b_in       (b_in),
    .b_in_sync  (b_in_sync),
    .m_out      (m_out),
    .m_out_valid(m_out_valid),
    .m_out_ready(m_out_ready),
    .grant_a    (grant_a),
    .grant_b    (grant_b),
    .section    (section),
    .cnt_a      (cnt_a),
    .cnt_b      (cnt_b)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Pulses reset between edges. The scheduler then starts from a clean state
  // with last_served = B.
  task automatic pulse_rst();
    rst = 1'b1;
    #2;
    rst = 1'b0;
  endtask

  task automatic check_idle_reset(input string tag);
    check({tag, "_m_out"},   m_out, 32'd1337);
    check({tag, "_valid"},   32'(m_out_valid), 0);
    check({tag, "_section"}, 32'(section), 0);
    check({tag, "_grant_a"}, 32'(grant_a), 0);
    check({tag, "_grant_b"}, 32'(grant_b), 0);
    check({tag, "_cnt_a"},   32'(cnt_a), 0);
    check({tag, "_cnt_b"},   32'(cnt_b), 0);
  endtask

  // Expected outputs for the tie / round-robin sequence, one row per edge.
  typedef struct {
    logic [31:0] m_out;
    logic        valid;
    logic        ga;
    logic        gb;
    logic [1:0]  sec;
    logic [7:0]  ca;
    logic [7:0]  cb;
  } rr_exp_t;

  rr_exp_t rr_tab [6];

  initial begin
    rr_tab[0] = '{32'd10, 1'b1, 1'b1, 1'b0, 2'd1, 8'd0, 8'd0};
    rr_tab[1] = '{32'd10, 1'b0, 1'b0, 1'b0, 2'd0, 8'd1, 8'd0};
    rr_tab[2] = '{32'd20, 1'b1, 1'b0, 1'b1, 2'd2, 8'd1, 8'd0};
    rr_tab[3] = '{32'd20, 1'b0, 1'b0, 1'b0, 2'd0, 8'd1, 8'd1};
    rr_tab[4] = '{32'd10, 1'b1, 1'b1, 1'b0, 2'd1, 8'd1, 8'd1};
    rr_tab[5] = '{32'd10, 1'b0, 1'b0, 1'b0, 2'd0, 8'd2, 8'd1};

    rst = 1'b1;
    a_in = '0; a_in_sync = 1'b0;
    b_in = '0; b_in_sync = 1'b0;
    m_out_ready = 1'b0;
    tick();
    tick();
    check_idle_reset("por");
    rst = 1'b0;

    // ---- single A transfer ----
    a_in = 32'd5; a_in_sync = 1'b1; m_out_ready = 1'b1;
    tick();
    check("single_m_out",   m_out, 32'd5);
    check("single_valid",   32'(m_out_valid), 1);
    check("single_grant_a", 32'(grant_a), 1);
    check("single_grant_b", 32'(grant_b), 0);
    check("single_sec1",    32'(section), 1);
    a_in_sync = 1'b0;
    tick();
    check("single_done_valid", 32'(m_out_valid), 0);
    check("single_done_cnt_a", 32'(cnt_a), 1);
    check("single_done_sec",   32'(section), 0);
    check("single_done_ga",    32'(grant_a), 0);
    check("single_done_m_out", m_out, 32'd5);

    // ---- idle hold after a transfer of 42 ----
    a_in = 32'd42; a_in_sync = 1'b1;
    tick();
    check("hold_capture", m_out, 32'd42);
    a_in_sync = 1'b0;
    tick();
    for (int i = 0; i < 10; i++) begin
      tick();
      check("hold_m_out",   m_out, 32'd42);
      check("hold_valid",   32'(m_out_valid), 0);
      check("hold_section", 32'(section), 0);
    end
    check("hold_cnt_a", 32'(cnt_a), 2);

    // ---- tie and round-robin ----
    pulse_rst();
    a_in = 32'd10; b_in = 32'd20;
    a_in_sync = 1'b1; b_in_sync = 1'b1; m_out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      check($sformatf("rr%0d_m_out", i),   m_out, rr_tab[i].m_out);
      check($sformatf("rr%0d_valid", i),   32'(m_out_valid), 32'(rr_tab[i].valid));
      check($sformatf("rr%0d_grant_a", i), 32'(grant_a), 32'(rr_tab[i].ga));
      check($sformatf("rr%0d_grant_b", i), 32'(grant_b), 32'(rr_tab[i].gb));
      check($sformatf("rr%0d_section", i), 32'(section), 32'(rr_tab[i].sec));
      check($sformatf("rr%0d_cnt_a", i),   32'(cnt_a), 32'(rr_tab[i].ca));
      check($sformatf("rr%0d_cnt_b", i),   32'(cnt_b), 32'(rr_tab[i].cb));
    end
    a_in_sync = 1'b0; b_in_sync = 1'b0;

    // ---- backpressure on B while A waits ----
    pulse_rst();
    b_in = 32'd7; b_in_sync = 1'b1; m_out_ready = 1'b0;
    tick();
    check("bp_capture_m_out", m_out, 32'd7);
    check("bp_capture_gb",    32'(grant_b), 1);
    check("bp_capture_sec",   32'(section), 2);
    b_in = 32'd9; b_in_sync = 1'b0;
    a_in = 32'd3; a_in_sync = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("bp_hold_m_out", m_out, 32'd7);
      check("bp_hold_valid", 32'(m_out_valid), 1);
      check("bp_hold_ga",    32'(grant_a), 0);
      check("bp_hold_gb",    32'(grant_b), 0);
      check("bp_hold_sec",   32'(section), 2);
    end
    m_out_ready = 1'b1;
    tick();
    check("bp_done_valid", 32'(m_out_valid), 0);
    check("bp_done_cnt_b", 32'(cnt_b), 1);
    check("bp_done_sec",   32'(section), 0);
    check("bp_done_ga",    32'(grant_a), 0);
    tick();
    check("bp_next_ga",    32'(grant_a), 1);
    check("bp_next_m_out", m_out, 32'd3);
    check("bp_next_sec",   32'(section), 1);
    a_in_sync = 1'b0;
    tick();
    check("bp_next_cnt_a", 32'(cnt_a), 1);

    // ---- asynchronous reset mid-SEND_B ----
    pulse_rst();
    b_in = 32'd8; b_in_sync = 1'b1; m_out_ready = 1'b0;
    tick();
    check("rst_pre_valid", 32'(m_out_valid), 1);
    check("rst_pre_sec",   32'(section), 2);
    b_in_sync = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    check_idle_reset("rst_mid");
    #1;
    rst = 1'b0;
    m_out_ready = 1'b1;
    tick();
    check("rst_after_cnt_b", 32'(cnt_b), 0);
    check("rst_after_valid", 32'(m_out_valid), 0);

    // ---- counter wrap: 256 A transfers ----
    pulse_rst();
    a_in_sync = 1'b1; m_out_ready = 1'b1;
    for (int i = 1; i <= 256; i++) begin
      a_in = 32'(i * 3);
      tick();
      check("wrap_grant_a", 32'(grant_a), 1);
      check("wrap_m_out",   m_out, 32'(i * 3));
      tick();
      check("wrap_cnt_a", 32'(cnt_a), 32'(i % 256));
    end
    check("wrap_final_cnt_a", 32'(cnt_a), 0);
    check("wrap_final_cnt_b", 32'(cnt_b), 0);
    a_in_sync = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  // grant_a and grant_b must never be high together.
  always @(negedge clk) begin
    if (!rst) check("grant_exclusive", 32'(grant_a & grant_b), 0);
  end

endmodule
